// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared constants and anode polarity helpers for the hex display scanner
package hex_display_pkg;

  localparam int NIBBLE_W             = 4;
  localparam int DEFAULT_REFRESH_DIV  = 50000;
  localparam int DEFAULT_BLANK_CYCLES = 500;

  // Level that switches a digit's anode on for the configured polarity.
  function automatic logic an_on(input bit active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

  // Level that keeps a digit's anode off for the configured polarity.
  function automatic logic an_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// rtl/scan_prescaler.sv - slot counter and digit index generator for the hex display scanner
module scan_prescaler
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  localparam int IW          = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [IW-1:0] idx_next,
  output logic          slot_start,
  output logic          blank_active,
  output logic          frame_end
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [IW-1:0] idx;
  logic          cnt_wrap;

  // Next slot position; the status flags describe the cycle about to begin,
  // except frame_end which marks the current (last) cycle of the frame.
  always_comb begin
    cnt_wrap     = (cnt == CNT_LAST);
    cnt_next     = cnt_wrap ? '0 : cnt + 1'b1;
    idx_next     = idx;
    if (cnt_wrap) begin
      idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    slot_start   = cnt_wrap;
    blank_active = (cnt_next < BLANK_END);
    frame_end    = cnt_wrap && (idx == IDX_LAST);
  end

  // Slot counter and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
    end
  end

endmodule

// File: rtl/hex_display_scan.sv
// rtl/hex_display_scan.sv - 7-seg display scanner with frame-synchronous shadow load; HEX_DISPLAY_SCAN_LZB_EN adds leading-zero blanking
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = DEFAULT_REFRESH_DIV,
  parameter int BLANK_CYCLES  = DEFAULT_BLANK_CYCLES,
  parameter int ACTIVE_LOW_AN = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]          dp_in,
  output logic [NIBBLE_W-1:0]            nibble,
  output logic                           dp,
  output logic [NUM_DIGITS-1:0]          an,
  output logic                           pend
);

  localparam int   IW         = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int   DW         = NIBBLE_W * NUM_DIGITS;
  localparam logic AN_ON_LVL  = an_on(ACTIVE_LOW_AN != 0);
  localparam logic AN_OFF_LVL = an_off(ACTIVE_LOW_AN != 0);

  logic [IW-1:0]         idx_next;
  logic                  slot_start;
  logic                  blank_active;
  logic                  frame_end;

  logic [DW-1:0]         disp, disp_next;
  logic [DW-1:0]         shadow, shadow_next;
  logic [NUM_DIGITS-1:0] disp_dp, disp_dp_next;
  logic [NUM_DIGITS-1:0] shadow_dp, shadow_dp_next;
  logic                  pend_next;
  logic [NIBBLE_W-1:0]   nibble_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;
  logic                  hide;

  scan_prescaler #(
    .NUM_DIGITS   (NUM_DIGITS),
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .idx_next     (idx_next),
    .slot_start   (slot_start),
    .blank_active (blank_active),
    .frame_end    (frame_end)
  );

  // Shadow/display update: loads park in the shadow until the frame
  // boundary; a load landing on the boundary itself goes straight through.
  always_comb begin
    disp_next      = disp;
    disp_dp_next   = disp_dp;
    shadow_next    = shadow;
    shadow_dp_next = shadow_dp;
    pend_next      = pend;
    if (frame_end) begin
      if (load) begin
        disp_next      = value;
        disp_dp_next   = dp_in;
        shadow_next    = value;
        shadow_dp_next = dp_in;
        pend_next      = 1'b0;
      end else if (pend) begin
        disp_next      = shadow;
        disp_dp_next   = shadow_dp;
        pend_next      = 1'b0;
      end
    end else if (load) begin
      shadow_next    = value;
      shadow_dp_next = dp_in;
      pend_next      = 1'b1;
    end
  end

  // Digit selection for the slot about to start; uses the post-boundary
  // display so a newly committed value appears from digit 0 of the frame.
  always_comb begin
    nibble_next = '0;
    dp_next     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (int'(idx_next) == i) begin
        nibble_next = disp_next[NIBBLE_W*i +: NIBBLE_W];
        dp_next     = disp_dp_next[i];
      end
    end
  end

`ifdef HEX_DISPLAY_SCAN_LZB_EN
  logic lzb_hide;
  logic lzb_hide_next;

  // A digit above 0 is suppressed when it and every digit to its left are
  // zero with no decimal point requested on it.
  always_comb begin
    lzb_hide_next = (idx_next != '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx_next)) begin
        if ((disp_next[NIBBLE_W*i +: NIBBLE_W] != '0) ||
            ((int'(idx_next) == i) && disp_dp_next[i])) begin
          lzb_hide_next = 1'b0;
        end
      end
    end
  end

  // Blanking decision is frozen at slot start for the whole slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      lzb_hide <= 1'b0;
    end else if (slot_start) begin
      lzb_hide <= lzb_hide_next;
    end
  end

  assign hide = blank_active || lzb_hide;
`else
  assign hide = blank_active;
`endif

  // Anode pattern for the next cycle: all off while blanking, else one-hot.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_next[i] = (!hide && (int'(idx_next) == i)) ? AN_ON_LVL : AN_OFF_LVL;
    end
  end

  // State and output registers; nibble/dp only change when a slot begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp      <= '0;
      disp_dp   <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      pend      <= 1'b0;
      nibble    <= '0;
      dp        <= 1'b0;
      an        <= {NUM_DIGITS{AN_OFF_LVL}};
    end else begin
      disp      <= disp_next;
      disp_dp   <= disp_dp_next;
      shadow    <= shadow_next;
      shadow_dp <= shadow_dp_next;
      pend      <= pend_next;
      an        <= an_next;
      if (slot_start) begin
        nibble <= nibble_next;
        dp     <= dp_next;
      end
    end
  end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Time-multiplexed scanner for a common-anode 4-digit seven-segment display.
- Sits directly upstream of hex_to_7seg: presents one hex nibble per time slot on `nibble`, which connects to hex_to_7seg input `a`.
- Drives the matching digit enable (`an`) and decimal point.
- Holds a shadow register so a new display value takes effect only at a frame boundary (no tearing).
- Inserts a blanking interval at the start of each slot to suppress ghosting.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- REFRESH_DIV, 50000: clock cycles per digit slot (>= 4).
- BLANK_CYCLES, 500: cycles at slot start with all anodes off; must satisfy 1 <= BLANK_CYCLES < REFRESH_DIV.
- ACTIVE_LOW_AN, 1: 1 = anode asserted as 0; 0 = asserted as 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle strobe; captures `value` and `dp_in`.
- value  in  4*NUM_DIGITS  hex digits; digit 0 = bits [3:0] (rightmost).
- dp_in  in  NUM_DIGITS  per-digit decimal-point request, bit i = digit i.
- nibble  out  4  hex digit of current slot; to hex_to_7seg `a`.
- dp  out  1  decimal point of current slot, active-high.
- an  out  NUM_DIGITS  digit enables, polarity per ACTIVE_LOW_AN.
- pend  out  1  a loaded value is waiting for the frame boundary.

Behaviour:
- All outputs are registers.
- Reset (rst=1 at an edge) sets: cnt=0, idx=0, disp=0, shadow=0, dp regs=0, pend=0, nibble=0, dp=0, an=all off. rst overrides load in the same cycle.
- Slot counter `cnt` runs 0..REFRESH_DIV-1, then wraps to 0. On wrap, `idx` increments modulo NUM_DIGITS (NUM_DIGITS-1 -> 0).
- Anode enables, registered on the same edge as cnt:
  - cnt < BLANK_CYCLES: `an` all off.
  - otherwise: only bit `idx` asserted.
- `nibble` = disp[4*idx +: 4] and `dp` = disp_dp[idx], registered alongside idx. Both are valid for the whole slot, including the blanking interval.
- Frame boundary = cycle with cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
- load=1 on a non-boundary cycle: shadow<=value, shadow_dp<=dp_in, pend<=1. A later load in the same frame overwrites the shadow (last write wins).
- At the frame boundary with pend=1 and no load: disp<=shadow, disp_dp<=shadow_dp, pend<=0. The new value is shown from idx=0 of the next frame.
- load=1 on the boundary cycle: value/dp_in are written directly into disp and shadow; pend<=0.
- pend=0 at the boundary: disp is unchanged.
- Frame period = NUM_DIGITS*REFRESH_DIV cycles; no stall or backpressure.
- Counter widths: $clog2(REFRESH_DIV) for cnt, $clog2(NUM_DIGITS) for idx (minimum 1 bit).

Optional Feature:
- Macro: HEX_DISPLAY_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - At the start of each slot, digit i's anode stays off for the whole slot if i>0, disp digits i..NUM_DIGITS-1 are all 0, and disp_dp[i]=0.
  - Digit 0 is never blanked, so value 0 displays "0".
- Not defined: every digit is lit outside blanking. No blanking logic is synthesized.

Decomposition:
- Shared package hex_display_pkg holds:
  - NIBBLE_W=4
  - AN_OFF/AN_ON helper function keyed on ACTIVE_LOW_AN
  - default REFRESH_DIV/BLANK_CYCLES constants
- One natural sub-module: scan_prescaler. It owns cnt and idx and emits slot_start, blank_active and frame_end.
- The top holds the shadow/display registers and the output muxing.

Test Plan:
- Bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, ACTIVE_LOW_AN=1, unless noted.
- Reset release: cycles 0-1 an=1111; cycles 2-7 an=1110 with nibble=0. Then cycles 10-15 an=1101 and cycles 18-23 an=1011; frame wraps at cycle 32.
- load 16'h1A2F, dp_in=4'b0100 at cycle 5: pend=1 through cycle 31; display stays 0. From cycle 32 nibble sequence is F,2,A,1 per slot, with dp=1 only in the idx=2 slot.
- Two loads in one frame, 16'h1111 then 16'h2222: next frame shows only 2,2,2,2.
- load 16'hBEEF exactly on the boundary cycle: pend stays 0; next cycle shows nibble=F, idx=0.
- rst asserted mid-slot with pend=1: next cycle shows an=1111, nibble=0, pend=0, cnt=0. A pending value is never shown.
- With HEX_DISPLAY_SCAN_LZB_EN:
  - 16'h0040: digits 3 and 2 are never enabled; digit 1 shows 4, digit 0 shows 0.
  - 16'h0000: only digit 0 is lit.
